// File: rtl/ifetch.sv
// ifetch: single-outstanding instruction fetch unit with a redirectable PC
// and a circular instruction buffer between the icache and the decoder.
module ifetch #(
   parameter int                  DATABITS  = 32,
   parameter int                  ADDRBITS  = 32,
   parameter int                  FIFODEPTH = 4,
   parameter logic [ADDRBITS-1:0] RESETPC   = '0
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic [ADDRBITS-1:0] icache_addr,
   output logic                icache_rdreq,
   input  logic [DATABITS-1:0] icache_out,
   input  logic                icache_out_valid,
   input  logic                icache_ready,
   input  logic                redirect_valid,
   input  logic [ADDRBITS-1:0] redirect_addr,
   output logic [DATABITS-1:0] instr,
   output logic [ADDRBITS-1:0] instr_pc,
   output logic                instr_valid,
   input  logic                instr_ready
);
   localparam int PW = $clog2(FIFODEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(FIFODEPTH);
   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DISCARD} state_t;
   state_t              state;
   logic [ADDRBITS-1:0] pc, req_pc, redirect_pc;
   logic [DATABITS-1:0] buf_data [FIFODEPTH];
   logic [ADDRBITS-1:0] buf_pc [FIFODEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [PW:0]         count;
   logic                push, pop;
   assign redirect_pc  = redirect_addr & ~ADDRBITS'(3);
   assign icache_addr  = pc;
   // Requests only issue from S_FETCH, so a full check on count alone keeps the buffer from overflowing.
   assign icache_rdreq = reset_n && state == S_FETCH && icache_ready && count < FULL && !redirect_valid;
   assign push         = state == S_WAIT && icache_out_valid && !redirect_valid;
   assign pop          = instr_ready && instr_valid;
   assign instr_valid  = count != '0;
   assign instr        = instr_valid ? buf_data[rd_ptr] : '0;
   assign instr_pc     = instr_valid ? buf_pc[rd_ptr] : '0;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state  <= S_FETCH;
         pc     <= RESETPC;
         req_pc <= '0;
      end else begin
         case (state)
            S_FETCH:
               if (redirect_valid) pc <= redirect_pc;
               else if (icache_rdreq) begin
                  req_pc <= pc;
                  state  <= S_WAIT;
               end
            S_WAIT:
               if (redirect_valid) begin
                  pc    <= redirect_pc;
                  state <= icache_out_valid ? S_FETCH : S_DISCARD;
               end else if (icache_out_valid) begin
                  pc    <= req_pc + ADDRBITS'(4);
                  state <= S_FETCH;
               end
            S_DISCARD: begin
               if (redirect_valid) pc <= redirect_pc;
               if (icache_out_valid) state <= S_FETCH;
            end
            default: state <= S_FETCH;
         endcase
      end
   always_ff @(posedge clk)
      if (push) begin
         buf_data[wr_ptr] <= icache_out;
         buf_pc[wr_ptr]   <= req_pc;
      end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr + PW'(pop);
         count  <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter DATABITS, default 32: instruction word width.
REQ-002 Parameter ADDRBITS, default 32: byte address width.
REQ-003 Parameter FIFODEPTH, default 4: instruction buffer entries; power of two, at least 2.
REQ-004 Parameter RESETPC, default 0: first fetch address after reset.
REQ-005 Port clk, input, 1: clock; all state changes on the rising edge.
REQ-006 Port reset_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port icache_addr, output, ADDRBITS: fetch byte address presented to the instruction cache.
REQ-008 Port icache_rdreq, output, 1: single-cycle read request strobe.
REQ-009 Port icache_out, input, DATABITS: returned instruction word.
REQ-010 Port icache_out_valid, input, 1: icache_out is valid in this cycle.
REQ-011 Port icache_ready, input, 1: cache accepts a request in this cycle.
REQ-012 Port redirect_valid, input, 1: branch/trap redirect strobe from the core.
REQ-013 Port redirect_addr, input, ADDRBITS: new fetch address.
REQ-014 Port instr, output, DATABITS: head-of-buffer instruction.
REQ-015 Port instr_pc, output, ADDRBITS: byte address of instr.
REQ-016 Port instr_valid, output, 1: buffer not empty.
REQ-017 Port instr_ready, input, 1: decoder consumes the head entry when both instr_valid and instr_ready are high.

Function
REQ-018 The FSM SHALL have three states: S_FETCH, S_WAIT and S_DISCARD.
REQ-019 In S_FETCH, when icache_ready=1, buffer count < FIFODEPTH and redirect_valid=0, the block SHALL drive icache_rdreq=1 for one cycle with icache_addr=pc, latch req_pc=pc and go to S_WAIT.
REQ-020 In S_WAIT, icache_out_valid=1 SHALL push {icache_out, req_pc} into the buffer, set pc=req_pc+4 and return to S_FETCH; the earliest next request is the following cycle.
REQ-021 At most one request SHALL be outstanding at any time.
REQ-022 icache_rdreq SHALL be 0 in S_WAIT and S_DISCARD.
REQ-023 icache_out_valid SHALL be ignored in S_FETCH.
REQ-024 A redirect in S_FETCH SHALL load pc with {redirect_addr[ADDRBITS-1:2], 2'b00}, flush the buffer and suppress a request in that cycle.
REQ-025 A redirect in S_WAIT without icache_out_valid SHALL load pc, flush the buffer and go to S_DISCARD.
REQ-026 A redirect in S_WAIT with icache_out_valid SHALL load pc, flush the buffer, drop the response and go to S_FETCH.
REQ-027 In S_DISCARD, icache_out_valid SHALL drop the response and return to S_FETCH without changing pc.
REQ-028 A further redirect in S_DISCARD SHALL only reload pc.
REQ-029 The buffer SHALL be a circular FIFO with log2(FIFODEPTH)-bit wrapping pointers and a (log2(FIFODEPTH)+1)-bit count.
REQ-030 A simultaneous push and pop SHALL leave count unchanged.
REQ-031 A push when count = FIFODEPTH SHALL be impossible by construction; a pop when empty SHALL be ignored.
REQ-032 On a redirect, pointers and count SHALL clear on the same edge; any pop or push in that cycle SHALL be discarded.
REQ-033 instr_valid SHALL be (count != 0); instr and instr_pc SHALL show the head entry with no added latency.
REQ-034 pc arithmetic SHALL be modulo 2^ADDRBITS; 0xFFFFFFFC + 4 wraps to 0.

Reset
REQ-035 While reset_n=0 the block SHALL hold state=S_FETCH, pc=RESETPC, req_pc=0, count=0, pointers=0, icache_rdreq=0, instr_valid=0, instr=0 and instr_pc=0.
REQ-036 Reset asserted mid-request SHALL abandon the request; a late icache_out_valid after release arrives in S_FETCH and SHALL be ignored.
REQ-037 The first request SHALL issue, to RESETPC, on the first edge after release when icache_ready=1.

Verification
REQ-038 Sequential fetch: RESETPC=0, icache_ready=1, one-cycle cache response, instr_ready=1 -> instr_pc sequence 0,4,8,C with words matching memory; never two requests without a response between.
REQ-039 Backpressure: instr_ready=0, FIFODEPTH=4 -> exactly 4 requests (addresses 0..C), then icache_rdreq stays 0; raising instr_ready for 1 cycle -> one request, to 0x10.
REQ-040 Redirect in S_WAIT: request to 0x8 pending, redirect_addr=0x103 -> response dropped, buffer empty, next request to 0x100.
REQ-041 Simultaneous redirect and response: redirect_addr=0x200 in the same cycle as icache_out_valid -> no push, next cycle in S_FETCH with request to 0x200.
REQ-042 Push and pop in the same cycle with count=2 -> count remains 2; pointer wrap after 9 entries with FIFODEPTH=4 -> ordering preserved.
REQ-043 Reset asserted while in S_WAIT, then icache_out_valid pulses after release -> no push, first request to RESETPC, instr_valid=0 throughout.
